mem_access_ctrl: RTL

- CPU-side initiator for the byte-addressed data RAM's MOV/MOC handshake; sits between the load/store datapath and the RAM.
- Translates SPARC op3 load/store codes into RAM OP codes and performs sign extension for signed loads.
- Checks alignment, splits LDD/STD into two word accesses, and times out an unresponsive RAM.

---
 rtl/mem_access_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CPU-side MOV/MOC initiator for the byte-addressed data RAM
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        op3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       wdata2,
  output logic [31:0]       rdata,
  output logic [31:0]       rdata2,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              mem_mov,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [5:0]        mem_op,
  input  logic [31:0]       mem_dout,
  input  logic              mem_moc
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_DONE, S_ERR} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  function automatic logic f_valid(input logic [5:0] code);
    case (code)
      6'b000000, 6'b000001, 6'b000010, 6'b000011,
      6'b000100, 6'b000101, 6'b000110, 6'b000111,
      6'b001001, 6'b001010: f_valid = 1'b1;
      default:              f_valid = 1'b0;
    endcase
  endfunction

  // 0 byte, 1 half, 2 word, 3 double
  function automatic logic [1:0] f_size(input logic [5:0] code);
    case (code)
      6'b000001, 6'b000101, 6'b001001: f_size = 2'd0;
      6'b000010, 6'b000110, 6'b001010: f_size = 2'd1;
      6'b000011, 6'b000111:            f_size = 2'd3;
      default:                         f_size = 2'd2;
    endcase
  endfunction

  function automatic logic [5:0] f_rop(input logic [5:0] code);
    case (code)
      6'b000001, 6'b001001: f_rop = 6'b000001;
      6'b000010, 6'b001010: f_rop = 6'b000010;
      6'b000100, 6'b000111: f_rop = 6'b000100;
      6'b000101:            f_rop = 6'b000101;
      6'b000110:            f_rop = 6'b000110;
      default:              f_rop = 6'b001000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, wdata2_q, wdata2_d;
  logic [31:0]       rdata_q, rdata_d, rdata2_q, rdata2_d;
  logic              beat_q, beat_d;
  logic              armed_q, armed_d;
  logic [1:0]        err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              misaligned, is_load, is_dbl, tmo;
  logic [31:0]       ext;

  assign is_load = ~op_q[2];
  assign is_dbl  = (f_size(op_q) == 2'd3);
  assign tmo     = (cnt_q == TMO_LAST);

  always_comb begin
    case (f_size(op3))
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = |addr[1:0];
      default: misaligned = |addr[2:0];
    endcase
  end

  always_comb begin
    case (op_q)
      6'b000001: ext = {24'b0, mem_dout[7:0]};
      6'b000010: ext = {16'b0, mem_dout[15:0]};
      6'b001001: ext = {{24{mem_dout[7]}}, mem_dout[7:0]};
      6'b001010: ext = {{16{mem_dout[15]}}, mem_dout[15:0]};
      default:   ext = mem_dout;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wdata2_d = wdata2_q;
    rdata_d  = rdata_q;
    rdata2_d = rdata2_q;
    beat_d   = beat_q;
    err_d    = err_q;
    cnt_d    = cnt_q + 8'd1;
    armed_d  = ~mem_moc;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (start) begin
          op_d     = op3;
          addr_d   = addr;
          wdata_d  = wdata;
          wdata2_d = wdata2;
          beat_d   = 1'b0;
          err_d    = 2'b00;
          if (!f_valid(op3)) begin
            err_d   = 2'b11;
            state_d = S_ERR;
          end else if (misaligned) begin
            err_d   = 2'b01;
            state_d = S_ERR;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // a MOC left high from an earlier access only counts once it has been seen low
        armed_d = armed_q | ~mem_moc;
        if (mem_moc && armed_q) begin
          if (is_load) begin
            if (is_dbl && beat_q) rdata2_d = mem_dout;
            else                  rdata_d  = ext;
          end
          cnt_d   = 8'd0;
          state_d = S_REL;
        end else if (tmo) begin
          err_d   = 2'b10;
          state_d = S_ERR;
        end
      end
      S_REL: begin
        if (!mem_moc) begin
          cnt_d = 8'd0;
          if (is_dbl && !beat_q) begin
            beat_d  = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_DONE;
          end
        end else if (tmo) begin
          err_d   = 2'b10;
          state_d = S_ERR;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wdata2_q <= '0;
      rdata_q  <= '0;
      rdata2_q <= '0;
      beat_q   <= 1'b0;
      armed_q  <= 1'b0;
      err_q    <= 2'b00;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wdata2_q <= wdata2_d;
      rdata_q  <= rdata_d;
      rdata2_q <= rdata2_d;
      beat_q   <= beat_d;
      armed_q  <= armed_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // RAM-side outputs are held at zero while idle so reset leaves every output low
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) || (state_q == S_ERR);
  assign err      = (state_q == S_ERR) ? err_q : 2'b00;
  assign rdata    = rdata_q;
  assign rdata2   = rdata2_q;
  assign mem_mov  = (state_q == S_REQ);
  assign mem_rw   = busy & is_load;
  assign mem_op   = busy ? f_rop(op_q) : 6'b000000;
  assign mem_addr = busy ? (beat_q ? addr_q + ADDR_W'(4) : addr_q) : '0;
  assign mem_din  = busy ? (beat_q ? wdata2_q : wdata_q) : 32'b0;

endmodule
